prog_loader: RTL and testbench

Byte-stream program loader that sits directly upstream of `top_core`'s testbench memory-write port. It receives a framed byte stream over a valid/ready link and produces the ICCM/DCCM pre-load writes: one full-mask 32-bit write per assembled word, with an auto-incrementing word address. After loading it raises the sticky `finish` signal that releases the core. It replaces hand-sequenced stimulus and is also the path for an on-chip boot bridge (UART/SPI front end).

---
 rtl/prog_loader_if.sv | 37 +++
 rtl/prog_loader.sv | 205 ++++++++++++++++++++
 tb/tb_prog_loader.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// ============================================================================
// Module : prog_loader_if
// Brief  : Byte-stream receive link plus memory pre-load write bundle.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface prog_loader_if #(
    parameter int AW = 11
);
    logic          rx_valid_i;
    logic [7:0]    rx_data_i;
    logic          rx_ready_o;
    logic          mem_we_o;
    logic          iccm_sel_o;
    logic [31:0]   wdata_o;
    logic [31:0]   wmask_o;
    logic [AW-1:0] waddr_o;
    logic          finish_o;
    logic          err_o;

    // Byte source / write sink side
    modport master (
        output rx_valid_i, rx_data_i,
        input  rx_ready_o, mem_we_o, iccm_sel_o, wdata_o, wmask_o, waddr_o,
               finish_o, err_o
    );

    // Loader side
    modport slave (
        input  rx_valid_i, rx_data_i,
        output rx_ready_o, mem_we_o, iccm_sel_o, wdata_o, wmask_o, waddr_o,
               finish_o, err_o
    );
endinterface

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
// Module : prog_loader
// Brief  : Framed byte-stream loader producing ICCM/DCCM word writes and a
//          sticky boot release. Optional trailing checksum: PROG_LOADER_CHECKSUM_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_loader #(
    parameter int AW = 11,
    parameter int CW = 16
) (
    input  wire logic     clk_i,
    input  wire logic     rst_ni,
    prog_loader_if.slave  bus
);

    localparam logic [7:0] c_CMD_ICCM = 8'hA5;
    localparam logic [7:0] c_CMD_DCCM = 8'h5A;
    localparam logic [7:0] c_CMD_BOOT = 8'hF0;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_ADDR_LO = 4'd1,
        S_ADDR_HI = 4'd2,
        S_CNT_LO  = 4'd3,
        S_CNT_HI  = 4'd4,
        S_DATA    = 4'd5,
        S_WRITE   = 4'd6,
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CSUM    = 4'd8,
`endif
        S_DONE    = 4'd7
    } state_t;

    state_t        r_state;
    logic          r_rx_ready;
    logic          r_mem_we;
    logic          r_iccm_sel;
    logic [31:0]   r_wdata;
    logic [31:0]   r_wmask;
    logic [AW-1:0] r_waddr;
    logic          r_finish;
    logic          r_err;
    logic [AW-1:0] r_addr;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_lo_byte;
    logic [23:0]   r_word;
    logic [1:0]    r_byte_idx;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]    r_csum;
`endif

    logic          w_xfer;
    logic [CW-1:0] w_cnt_new;

    assign w_xfer    = bus.rx_valid_i & r_rx_ready;
    assign w_cnt_new = CW'({bus.rx_data_i, r_lo_byte});

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_rx_ready <= 1'b0;
            r_mem_we   <= 1'b0;
            r_iccm_sel <= 1'b0;
            r_wdata    <= '0;
            r_wmask    <= '0;
            r_waddr    <= '0;
            r_finish   <= 1'b0;
            r_err      <= 1'b0;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_lo_byte  <= '0;
            r_word     <= '0;
            r_byte_idx <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_csum     <= '0;
`endif
        end else begin
            // Ready is registered alongside the state: low only in WRITE.
            r_rx_ready <= 1'b1;
            r_mem_we   <= 1'b0;
            r_wmask    <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        case (bus.rx_data_i)
                            c_CMD_ICCM, c_CMD_DCCM: begin
                                r_iccm_sel <= (bus.rx_data_i == c_CMD_ICCM);
                                r_state    <= S_ADDR_LO;
`ifdef PROG_LOADER_CHECKSUM_EN
                                r_csum     <= '0;
`endif
                            end
                            c_CMD_BOOT: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                                if (!r_err) begin
                                    r_finish <= 1'b1;
                                    r_state  <= S_DONE;
                                end
`else
                                r_finish <= 1'b1;
                                r_state  <= S_DONE;
`endif
                            end
                            default: r_err <= 1'b1;
                        endcase
                    end
                end
                S_ADDR_LO: begin
                    if (w_xfer) begin
                        r_lo_byte <= bus.rx_data_i;
                        r_state   <= S_ADDR_HI;
                    end
                end
                S_ADDR_HI: begin
                    if (w_xfer) begin
                        r_addr  <= AW'({bus.rx_data_i, r_lo_byte});
                        r_state <= S_CNT_LO;
                    end
                end
                S_CNT_LO: begin
                    if (w_xfer) begin
                        r_lo_byte <= bus.rx_data_i;
                        r_state   <= S_CNT_HI;
                    end
                end
                S_CNT_HI: begin
                    if (w_xfer) begin
                        r_cnt      <= w_cnt_new;
                        r_byte_idx <= '0;
                        if (w_cnt_new == '0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            r_state <= S_CSUM;
`else
                            r_state <= S_IDLE;
`endif
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_csum <= r_csum ^ bus.rx_data_i;
`endif
                        if (r_byte_idx == 2'd3) begin
                            r_wdata    <= {bus.rx_data_i, r_word};
                            r_waddr    <= r_addr;
                            r_mem_we   <= 1'b1;
                            r_wmask    <= '1;
                            r_rx_ready <= 1'b0;
                            r_byte_idx <= '0;
                            r_state    <= S_WRITE;
                        end else begin
                            // Little-endian: earlier bytes shift toward bit 0
                            r_word     <= {bus.rx_data_i, r_word[23:8]};
                            r_byte_idx <= r_byte_idx + 2'd1;
                        end
                    end
                end
                S_WRITE: begin
                    r_addr <= r_addr + AW'(1);
                    r_cnt  <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_state <= S_CSUM;
`else
                        r_state <= S_IDLE;
`endif
                    end else begin
                        r_state <= S_DATA;
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (w_xfer) begin
                        if (bus.rx_data_i != r_csum) begin
                            r_err <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end
                end
`endif
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rx_ready_o = r_rx_ready;
    assign bus.mem_we_o   = r_mem_we;
    assign bus.iccm_sel_o = r_iccm_sel;
    assign bus.wdata_o    = r_wdata;
    assign bus.wmask_o    = r_wmask;
    assign bus.waddr_o    = r_waddr;
    assign bus.finish_o   = r_finish;
    assign bus.err_o      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
// Module : tb_prog_loader
// Brief  : Self-checking bench for prog_loader: frame table, random frames,
//          reset, boot and error sequences against a write-list model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_prog_loader;

    localparam int AW = 11;
    localparam int CW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prog_loader_if #(.AW(AW)) bus ();

    prog_loader #(.AW(AW), .CW(CW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    typedef struct {
        logic          sel;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    typedef logic [31:0] wq_t[$];

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] addr;
        int          cnt;
        int          gap;
        bit          plan_words;
        logic        exp_sel;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;
    wr_t  got_q[$];
    wr_t  exp_q[$];
    wq_t  plan_words;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Caller is always at posedge+1 on entry and exit.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        bit rdy;
        repeat ($urandom_range(gap, 0)) begin
            @(posedge clk); #1;
        end
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = b;
        n   = 0;
        rdy = 1'b0;
        while (!rdy && n < 20) begin
            @(negedge clk);
            rdy = bus.rx_ready_o;
            @(posedge clk); #1;
            n++;
        end
        bus.rx_valid_i = 1'b0;
        if (!rdy) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: byte 0x%0h not accepted within 20 cycles", b);
        end
    endtask

    task automatic send_load(input logic [7:0] cmd, input logic [15:0] addr, input int cnt,
                             input wq_t words, input int gap, input bit bad_csum);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        send_byte(cmd, gap);
        send_byte(addr[7:0], gap);
        send_byte(addr[15:8], gap);
        send_byte(cnt[7:0], gap);
        send_byte(cnt[15:8], gap);
        for (int i = 0; i < words.size(); i++) begin
            for (int k = 0; k < 4; k++) begin
                b = words[i][8*k +: 8];
                x = x ^ b;
                send_byte(b, gap);
            end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(bad_csum ? ~x : x, gap);
`else
        if (bad_csum) x = ~x;
`endif
    endtask

    // Model: a load of N words lands at consecutive addresses modulo 2^AW.
    task automatic expect_load(input logic sel, input logic [15:0] addr, input wq_t words);
        wr_t w;
        for (int i = 0; i < words.size(); i++) begin
            w.sel  = sel;
            w.addr = AW'((int'(addr) + i) % (1 << AW));
            w.data = words[i];
            exp_q.push_back(w);
        end
    endtask

    task automatic check_writes(input string name);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk({name, "_nwrites"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                chk({name, "_sel"},  got_q[i].sel,  exp_q[i].sel);
                chk({name, "_addr"}, got_q[i].addr, exp_q[i].addr);
                chk({name, "_data"}, got_q[i].data, exp_q[i].data);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic rand_words(input int n, output wq_t q);
        q.delete();
        for (int i = 0; i < n; i++) q.push_back($urandom);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        chk("rst_ready",  bus.rx_ready_o, 0);
        chk("rst_we",     bus.mem_we_o,   0);
        chk("rst_sel",    bus.iccm_sel_o, 0);
        chk("rst_wdata",  bus.wdata_o,    0);
        chk("rst_wmask",  bus.wmask_o,    0);
        chk("rst_waddr",  bus.waddr_o,    0);
        chk("rst_finish", bus.finish_o,   0);
        chk("rst_err",    bus.err_o,      0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst_ready", bus.rx_ready_o, 1);
        mon_en = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        wq_t  words;
        wr_t  w;

        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = 8'h00;
        plan_words = '{32'h40080437, 32'h00a00613, 32'h01400693, 32'h00d60733};

        tbl[0] = '{8'hA5, 16'h0000, 4, 0, 1'b1, 1'b1};
        tbl[1] = '{8'h5A, 16'h07FF, 2, 0, 1'b0, 1'b0};
        tbl[2] = '{8'hA5, 16'h0000, 4, 4, 1'b1, 1'b1};
        tbl[3] = '{8'h5A, 16'hF9FE, 3, 2, 1'b0, 1'b0};
        tbl[4] = '{8'hA5, 16'h0123, 0, 1, 1'b0, 1'b1};
        tbl[5] = '{8'h5A, 16'h03FF, 5, 3, 1'b0, 1'b0};

        // Write monitor: ready must be low exactly in write cycles.
        fork
            forever begin
                @(negedge clk);
                if (mon_en) begin
                    chk("ready_vs_we", bus.rx_ready_o, !bus.mem_we_o);
                    if (bus.mem_we_o) begin
                        chk("wmask_on", bus.wmask_o, 32'hFFFF_FFFF);
                        chk("finish_with_we", bus.finish_o, 0);
                        w.sel  = bus.iccm_sel_o;
                        w.addr = bus.waddr_o;
                        w.data = bus.wdata_o;
                        got_q.push_back(w);
                    end else begin
                        chk("wmask_off", bus.wmask_o, 0);
                    end
                end
            end
        join_none

        @(posedge clk); #1;
        do_reset();

        for (int v = 0; v < 6; v++) begin
            if (tbl[v].plan_words) words = plan_words;
            else rand_words(tbl[v].cnt, words);
            expect_load(tbl[v].exp_sel, tbl[v].addr, words);
            send_load(tbl[v].cmd, tbl[v].addr, tbl[v].cnt, words, tbl[v].gap, 1'b0);
            check_writes($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_sel_hold", v), bus.iccm_sel_o, tbl[v].exp_sel);
            chk($sformatf("vec%0d_err", v), bus.err_o, 0);
            chk($sformatf("vec%0d_finish", v), bus.finish_o, 0);
        end

        for (int r = 0; r < 8; r++) begin
            logic [7:0]  cmd;
            logic [15:0] addr;
            int          cnt;
            cmd  = ($urandom_range(1, 0) == 1) ? 8'hA5 : 8'h5A;
            addr = 16'($urandom);
            cnt  = $urandom_range(5, 1);
            rand_words(cnt, words);
            expect_load(cmd == 8'hA5, addr, words);
            send_load(cmd, addr, cnt, words, $urandom_range(3, 0), 1'b0);
            check_writes($sformatf("rand%0d", r));
        end

        // Unknown command: sticky error, FSM keeps accepting frames from IDLE.
        chk("err_before_bad", bus.err_o, 0);
        send_byte(8'h33, 0);
        @(negedge clk);
        chk("err_after_bad", bus.err_o, 1);
        @(posedge clk); #1;
        rand_words(1, words);
        expect_load(1'b1, 16'h0042, words);
        send_load(8'hA5, 16'h0042, 1, words, 0, 1'b0);
        check_writes("after_bad");
        send_byte(8'hF0, 0);
        @(negedge clk);
`ifdef PROG_LOADER_CHECKSUM_EN
        chk("boot_with_err", bus.finish_o, 0);
`else
        chk("boot_with_err", bus.finish_o, 1);
`endif
        @(posedge clk); #1;

        // Reset after two data bytes of a word.
        do_reset();
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        chk("midword_nowrite", got_q.size(), 0);
        do_reset();
        chk("midword_nowrite_after", got_q.size(), 0);
        rand_words(2, words);
        expect_load(1'b1, 16'h0005, words);
        send_load(8'hA5, 16'h0005, 2, words, 1, 1'b0);
        check_writes("after_reset");

        // Boot: finish one cycle after F0, later bytes discarded.
        chk("finish_before_boot", bus.finish_o, 0);
        send_byte(8'hF0, 0);
        @(negedge clk);
        chk("finish_after_boot", bus.finish_o, 1);
        @(posedge clk); #1;
        rand_words(1, words);
        send_load(8'hA5, 16'h0000, 1, words, 1, 1'b0);
        send_byte(8'h77, 0);
        check_writes("done_discard");
        chk("done_finish_sticky", bus.finish_o, 1);
        chk("done_err", bus.err_o, 0);

`ifdef PROG_LOADER_CHECKSUM_EN
        do_reset();
        rand_words(2, words);
        expect_load(1'b0, 16'h0100, words);
        send_load(8'h5A, 16'h0100, 2, words, 1, 1'b0);
        check_writes("csum_good");
        chk("csum_good_err", bus.err_o, 0);
        rand_words(1, words);
        expect_load(1'b1, 16'h0010, words);
        send_load(8'hA5, 16'h0010, 1, words, 0, 1'b1);
        check_writes("csum_bad");
        chk("csum_bad_err", bus.err_o, 1);
        send_byte(8'hF0, 0);
        @(negedge clk);
        chk("csum_bad_finish", bus.finish_o, 0);
        @(posedge clk); #1;
`endif

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
